fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 13 +
 rtl/if_id_reg.sv | 52 +++++
 rtl/fetch_unit.sv | 98 +++++++++
 tb/tb_fetch_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and state encoding for the instruction fetch unit
package fetch_pkg;

  localparam int PC_INC   = 4;
  localparam int OPCODE_W = 6;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_KILL = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register: load beats clear, clear beats hold
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic               clear_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    pc_o
);

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (load_i) begin
      valid_d = 1'b1;
      instr_d = instr_i;
      pc_d    = pc_i;
    end else if (clear_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC, request/kill FSM and IF/ID register
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter int              INSTR_W  = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               pc_src,
  input  logic [PC_W-1:0]    branch_target,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic [5:0]         opcode
);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            capture;
  logic            clear_buf;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    capture   = 1'b0;
    clear_buf = 1'b0;
    unique case (state_q)
      S_REQ: begin
        if (pc_src) begin
          pc_d      = branch_target;
          clear_buf = 1'b1;
          state_d   = imem_ack ? S_REQ : S_KILL;
        end else if (imem_ack) begin
          capture = 1'b1;
          pc_d    = pc_q + PC_W'(PC_INC);
          state_d = stall ? S_HOLD : S_REQ;
        end else if (!stall) begin
          clear_buf = 1'b1;
        end
      end
      S_HOLD: begin
        if (pc_src) begin
          pc_d      = branch_target;
          clear_buf = 1'b1;
          state_d   = S_REQ;
        end else if (!stall) begin
          clear_buf = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_KILL: begin
        // An ack here answers the abandoned request; once it lands nothing is in flight.
        clear_buf = pc_src || !stall;
        if (pc_src) pc_d = branch_target;
        if (imem_ack) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign imem_req  = !reset && (state_q == S_REQ);
  assign imem_addr = pc_q;

  if_id_reg #(
    .PC_W   (PC_W),
    .INSTR_W(INSTR_W)
  ) u_if_id (
    .clk_i  (clk),
    .reset_i(reset),
    .load_i (capture),
    .clear_i(clear_buf),
    .instr_i(imem_rdata),
    .pc_i   (pc_q),
    .valid_o(if_valid),
    .instr_o(if_instr),
    .pc_o   (if_pc)
  );

  assign opcode = if_valid ? if_instr[INSTR_W-1 -: OPCODE_W] : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset, imem_req, imem_ack, stall, pc_src, if_valid;
  logic [31:0] imem_addr, imem_rdata, branch_target, if_instr, if_pc;
  logic [5:0]  opcode;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;

  fetch_unit #(.PC_W(32), .INSTR_W(32), .RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .pc_src       (pc_src),
    .branch_target(branch_target),
    .if_valid     (if_valid),
    .if_instr     (if_instr),
    .if_pc        (if_pc),
    .opcode       (opcode)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1; imem_ack = 1'b0; stall = 1'b0; pc_src = 1'b0;
    imem_rdata = '0; branch_target = '0;
    tick; tick;
    reset = 1'b0;
    #1;
    sb.delete();
  endtask

  task automatic test_reset;
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    stall = 1'b0; pc_src = 1'b0; branch_target = '0;
    tick; tick; tick;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %0b want 0", imem_req); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", if_valid); end
    checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h want 0", if_instr); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", if_pc); end
    checks++; if (opcode !== 6'h0) begin errors++; $display("FAIL rst_opcode: got %h want 0", opcode); end
    reset = 1'b0; imem_ack = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %0b want 1", imem_req); end
    checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL first_addr: got %h want %h", imem_addr, RESET_PC); end
  endtask

  task automatic test_sequential;
    do_reset;
    for (int i = 0; i < 6; i++) begin
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL seq_req[%0d]: got %0b want 1", i, imem_req); end
      checks++; if (imem_addr !== 32'(4 * i)) begin errors++; $display("FAIL seq_addr[%0d]: got %h want %h", i, imem_addr, 32'(4 * i)); end
      imem_ack = 1'b1; imem_rdata = 32'h8C00_0000;
      sb.push_back('{pc: 32'(4 * i), instr: 32'h8C00_0000});
      tick;
      checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d]: got %0b want 1", i, if_valid); end
      checks++;
      if (sb.size() == 0) begin errors++; $display("FAIL seq_sb[%0d]: got empty want entry", i); end
      else begin
        e = sb.pop_front();
        if (if_pc !== e.pc || if_instr !== e.instr) begin
          errors++; $display("FAIL seq_data[%0d]: got pc=%h instr=%h want pc=%h instr=%h", i, if_pc, if_instr, e.pc, e.instr);
        end
      end
      checks++; if (opcode !== 6'h23) begin errors++; $display("FAIL seq_opcode[%0d]: got %h want 23", i, opcode); end
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_stall;
    do_reset;
    imem_ack = 1'b1; imem_rdata = 32'h8C00_0000;
    sb.push_back('{pc: 32'h0, instr: 32'h8C00_0000});
    tick;
    void'(sb.pop_front());
    imem_rdata = 32'h2000_0004; stall = 1'b1;
    sb.push_back('{pc: 32'h4, instr: 32'h2000_0004});
    tick;
    checks++;
    if (sb.size() == 0) begin errors++; $display("FAIL stall_sb: got empty want entry"); end
    else begin
      e = sb.pop_front();
      if (if_pc !== e.pc || if_instr !== e.instr || if_valid !== 1'b1) begin
        errors++; $display("FAIL stall_cap: got v=%0b pc=%h instr=%h want v=1 pc=%h instr=%h", if_valid, if_pc, if_instr, e.pc, e.instr);
      end
    end
    imem_ack = 1'b0;
    for (int j = 0; j < 5; j++) begin
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_req[%0d]: got %0b want 0", j, imem_req); end
      checks++;
      if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_instr !== 32'h2000_0004) begin
        errors++; $display("FAIL hold_data[%0d]: got v=%0b pc=%h instr=%h want v=1 pc=4 instr=20000004", j, if_valid, if_pc, if_instr);
      end
      imem_ack = (j == 2); imem_rdata = 32'hBAD0_BAD0;
      tick;
    end
    imem_ack = 1'b0; stall = 1'b0;
    tick;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL resume: got req=%0b addr=%h want req=1 addr=8", imem_req, imem_addr); end
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL resume_valid: got %0b want 0", if_valid); end
  endtask

  task automatic test_kill;
    pc_src = 1'b1; branch_target = 32'h100;
    tick;
    pc_src = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL kill_idle[%0d]: got req=%0b v=%0b want 0 0", k, imem_req, if_valid); end
      tick;
    end
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick;
    imem_ack = 1'b0;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL kill_discard: got v=%0b want 0", if_valid); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL kill_redirect: got req=%0b addr=%h want req=1 addr=100", imem_req, imem_addr); end
  endtask

  task automatic test_branch_ack;
    imem_ack = 1'b1; imem_rdata = 32'h8C00_0100;
    sb.push_back('{pc: 32'h100, instr: 32'h8C00_0100});
    tick;
    checks++;
    if (sb.size() == 0) begin errors++; $display("FAIL br_sb: got empty want entry"); end
    else begin
      e = sb.pop_front();
      if (if_pc !== e.pc || if_instr !== e.instr || if_valid !== 1'b1) begin
        errors++; $display("FAIL br_cap: got v=%0b pc=%h instr=%h want v=1 pc=%h instr=%h", if_valid, if_pc, if_instr, e.pc, e.instr);
      end
    end
    imem_rdata = 32'h1234_5678; pc_src = 1'b1; stall = 1'b1; branch_target = 32'h200;
    tick;
    imem_ack = 1'b0; pc_src = 1'b0; stall = 1'b0;
    checks++; if (if_valid !== 1'b0 || opcode !== 6'h0) begin errors++; $display("FAIL br_ack_valid: got v=%0b op=%h want 0 0", if_valid, opcode); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL br_ack_addr: got req=%0b addr=%h want req=1 addr=200", imem_req, imem_addr); end
  endtask

  task automatic test_wrap;
    pc_src = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick;
    pc_src = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h0BAD_0000;
    tick;
    imem_ack = 1'b0;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req: got req=%0b addr=%h want req=1 addr=fffffffc", imem_req, imem_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h8C00_00FF;
    sb.push_back('{pc: 32'hFFFF_FFFC, instr: 32'h8C00_00FF});
    tick;
    imem_ack = 1'b0;
    checks++;
    if (sb.size() == 0) begin errors++; $display("FAIL wrap_sb: got empty want entry"); end
    else begin
      e = sb.pop_front();
      if (if_pc !== e.pc || if_instr !== e.instr) begin
        errors++; $display("FAIL wrap_cap: got pc=%h instr=%h want pc=%h instr=%h", if_pc, if_instr, e.pc, e.instr);
      end
    end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h want 0", imem_addr); end
  endtask

  task automatic test_reset_hold;
    imem_ack = 1'b1; stall = 1'b1; imem_rdata = 32'h8C00_0000;
    sb.push_back('{pc: 32'h0, instr: 32'h8C00_0000});
    tick;
    imem_ack = 1'b0;
    checks++;
    if (sb.size() == 0) begin errors++; $display("FAIL rh_sb: got empty want entry"); end
    else begin
      e = sb.pop_front();
      if (if_valid !== 1'b1 || if_pc !== e.pc || imem_req !== 1'b0) begin
        errors++; $display("FAIL rh_hold: got v=%0b pc=%h req=%0b want v=1 pc=%h req=0", if_valid, if_pc, imem_req, e.pc);
      end
    end
    reset = 1'b1; imem_ack = 1'b1;
    tick;
    checks++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0 || if_instr !== 32'h0 || if_pc !== 32'h0 || opcode !== 6'h0) begin
      errors++; $display("FAIL rh_reset: got req=%0b v=%0b instr=%h pc=%h op=%h want all 0", imem_req, if_valid, if_instr, if_pc, opcode);
    end
    reset = 1'b0; stall = 1'b0; imem_ack = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin errors++; $display("FAIL rh_first: got req=%0b addr=%h want req=1 addr=%h", imem_req, imem_addr, RESET_PC); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_sequential;
    test_stall;
    test_kill;
    test_branch_ack;
    test_wrap;
    test_reset_hold;
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d want 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
